// File: rtl/mem_word_initiator.sv
// Word-to-byte memory initiator: turns 16-bit little-endian word requests into two
// byte accesses on a byte-wide memory with registered read data.
module mem_word_initiator #(
  parameter int unsigned MEM_ADDR_BITS = 14
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StRdWait,
    StWrLo,
    StWrHi,
    StResp
  } state_e;

  // Bits set for the implemented byte-address range.
  localparam logic [15:0] AddrMask = 16'((32'd1 << MEM_ADDR_BITS) - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_hi_q, wdata_hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] addr_next;

  // High byte address wraps inside the implemented range.
  assign addr_next = (addr_q + 16'd1) & AddrMask;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_hi_d   = wdata_hi_q;
    lo_d         = lo_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_hi_d = req_wdata[15:8];
          if ((req_addr & ~AddrMask) != 16'd0) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 16'd0;
          end else if (req_write) begin
            state_d     = StWrLo;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata[7:0];
            mem_we_d    = 1'b1;
          end else begin
            state_d    = StRdLo;
            mem_addr_d = req_addr;
          end
        end
      end
      StRdLo: begin
        state_d    = StRdHi;
        mem_addr_d = addr_next;
      end
      StRdHi: begin
        // Memory returns the low byte one edge after its address.
        state_d = StRdWait;
        lo_d    = mem_rdata;
      end
      StRdWait: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = {mem_rdata, lo_q};
      end
      StWrLo: begin
        state_d     = StWrHi;
        mem_addr_d  = addr_next;
        mem_wdata_d = wdata_hi_q;
        mem_we_d    = 1'b1;
      end
      StWrHi: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 16'd0;
      end
      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 16'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= 16'd0;
      wdata_hi_q   <= 8'd0;
      lo_q         <= 8'd0;
      mem_addr_q   <= 16'd0;
      mem_wdata_q  <= 8'd0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_hi_q   <= wdata_hi_d;
      lo_q         <= lo_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule
